ibex_fetch_req_ctrl: RTL and testbench
======================================

# ibex_fetch_req_ctrl

Request-side controller for the instruction fetch path. Issues word-aligned instruction-memory requests and tracks up to NUM_REQS outstanding responses. Forwards non-discarded responses to the fetch FIFO as its push port, and redirects the FIFO on branches. Sits between the core's branch/fetch-enable signals, the instruction bus (req/gnt/rvalid), and the fetch FIFO.

## Interface
- NUM_REQS, 2, maximum outstanding (granted, unanswered) requests; must match the fetch FIFO's NUM_REQS
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous, active-low reset
- req_i  in  1  fetch enable
- branch_i  in  1  redirect fetch to addr_i this cycle
- addr_i  in  32  branch target (halfword-aligned, bit 0 ignored)
- fifo_busy_i  in  NUM_REQS  FIFO occupancy of its top NUM_REQS entries (bit NUM_REQS-1 = last entry)
- fifo_clear_o  out  1  FIFO clear, equals branch_i
- fifo_valid_o  out  1  push response into FIFO
- fifo_addr_o  out  32  FIFO restart address, equals addr_i
- fifo_rdata_o  out  32  response data, equals instr_rdata_i
- fifo_err_o  out  1  response error, equals instr_err_i
- instr_req_o  out  1  bus request
- instr_gnt_i  in  1  bus grant
- instr_addr_o  out  32  bus address, bits [1:0] always 0
- instr_rvalid_i  in  1  bus response valid
- instr_rdata_i  in  32  bus response data
- instr_err_i  in  1  bus response error
- busy_o  out  1  |outstanding_q or instr_req_o

## Operation
- State:
  - outstanding_q[NUM_REQS-1:0], thermometer-coded; bit 0 = oldest.
  - discard_q[NUM_REQS-1:0], per-slot drop flag.
  - valid_req_q: request issued, not yet granted.
  - stored_addr_q[31:2]: address of the pending ungranted request.
  - fetch_addr_q[31:2]: next sequential word.
- fifo_ready = ~&(fifo_busy_i | outstanding_rev), where outstanding_rev is outstanding_q bit-reversed.
- valid_new_req = req_i & (fifo_ready | branch_i) & ~outstanding_q[NUM_REQS-1].
- instr_req_o = valid_req_q | valid_new_req.
- instr_addr_o = branch_i ? {addr_i[31:2],00} : valid_req_q ? {stored_addr_q,00} : {fetch_addr_q,00}.
- Grant is accepted when instr_req_o & instr_gnt_i. Without a grant, valid_req_q stays set.
  - req_i falling does not retract a pending request.
  - valid_req_q clears only on grant.
- stored_addr_q:
  - Loads instr_addr_o[31:2] when instr_req_o & ~instr_gnt_i and (branch_i | ~valid_req_q).
  - A branch during a pending request re-targets it.
- fetch_addr_q:
  - On branch_i: loads addr_i[31:2] + grant.
  - Else, on grant with ~valid_req_q: loads fetch_addr_q + 1.
  - Else, on grant of a pending request: loads stored_addr_q + 1.
- outstanding_q:
  - rvalid shifts right by one.
  - Grant sets the lowest clear bit after the shift.
  - rvalid and grant in the same cycle leave the count unchanged.
- discard_q:
  - Shifts with outstanding_q.
  - On branch_i, every bit whose outstanding_q bit is set becomes 1.
  - The slot granted in the branch cycle is 0.
- Response routing:
  - fifo_valid_o = instr_rvalid_i & ~discard_q[0].
  - A discarded response is consumed with no FIFO push.
  - instr_rvalid_i with outstanding_q[0]=0 is a protocol violation; no assertion in RTL.
- Errors pass through unchanged. The FIFO handles the err/err_plus2 split.

## Timing
- Reset values:
  - outstanding_q=0, discard_q=0, valid_req_q=0, stored_addr_q=0, fetch_addr_q=0.
  - instr_req_o=0 while req_i=0.
  - fifo_valid_o=0, busy_o=0.
- Request path is combinational from req_i/branch_i/fifo_busy_i; no added latency.
  - Back-to-back grants allowed every cycle until NUM_REQS are outstanding.
- rvalid to fifo_valid_o: 0 cycles (combinational pass-through).
- Branch is zero-cycle: the redirected request appears with branch_i.
  - fifo_clear_o asserts in the same cycle.
  - The response to that request arrives at the earliest the following cycle.
- Full: with outstanding_q[NUM_REQS-1]=1, no new request until an rvalid, even with branch_i.
  - The branch target is still latched into fetch_addr_q (no grant term).
- Reset mid-operation clears all tracking. Responses arriving after reset from pre-reset requests are out of protocol.

## Test plan
- Reset then req_i=1, branch_i=1, addr_i=0x100, gnt=1 every cycle:
  - instr_addr_o = 0x100, then 0x104.
  - The third request is blocked (busy_o=1) until rvalid.
  - Each rvalid gives fifo_valid_o=1 with the data passed through.
- Branch to 0x206 with gnt=0 for 3 cycles:
  - instr_req_o is held and instr_addr_o=0x204 throughout.
  - After the grant cycle the next address is 0x208.
- Two requests outstanding (0x100, 0x104), then branch_i to 0x400 with gnt:
  - The next two rvalids give fifo_valid_o=0.
  - The third rvalid (for 0x400) gives fifo_valid_o=1.
  - fifo_clear_o=1 only in the branch cycle.
- fifo_busy_i=2'b11 with none outstanding: instr_req_o=0 while req_i=1.
  - With fifo_busy_i=2'b01: exactly one request is issued, and a second is blocked until busy drops.
- Simultaneous rvalid and grant with one outstanding:
  - outstanding_q stays at 1.
  - instr_err_i=1 on rvalid gives fifo_err_o=1.
- rst_ni asserted with a pending ungranted request: instr_req_o=0 and busy_o=0 immediately (asynchronous).

Source files
------------

// File: rtl/ibex_fetch_req_ctrl.sv
// Instruction fetch request controller: issues word-aligned bus requests, tracks
// up to NUM_REQS outstanding responses and forwards non-discarded ones to the FIFO.
module ibex_fetch_req_ctrl #(
  parameter int unsigned NUM_REQS = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_i,
  input  logic                branch_i,
  input  logic [31:0]         addr_i,
  input  logic [NUM_REQS-1:0] fifo_busy_i,
  output logic                fifo_clear_o,
  output logic                fifo_valid_o,
  output logic [31:0]         fifo_addr_o,
  output logic [31:0]         fifo_rdata_o,
  output logic                fifo_err_o,
  output logic                instr_req_o,
  input  logic                instr_gnt_i,
  output logic [31:0]         instr_addr_o,
  input  logic                instr_rvalid_i,
  input  logic [31:0]         instr_rdata_i,
  input  logic                instr_err_i,
  output logic                busy_o
);

  logic [NUM_REQS-1:0] outstanding_q, outstanding_d;
  logic [NUM_REQS-1:0] discard_q, discard_d;
  logic                valid_req_q, valid_req_d;
  logic [31:2]         stored_addr_q, stored_addr_d;
  logic [31:2]         fetch_addr_q, fetch_addr_d;

  logic [NUM_REQS-1:0] outstanding_rev;
  logic [NUM_REQS-1:0] out_shift, disc_shift, new_slot;
  logic                fifo_ready, valid_new_req, gnt;

  always_comb begin
    outstanding_rev = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      outstanding_rev[i] = outstanding_q[NUM_REQS-1-i];
    end
  end

  assign fifo_ready    = ~&(fifo_busy_i | outstanding_rev);
  assign valid_new_req = req_i & (fifo_ready | branch_i) & ~outstanding_q[NUM_REQS-1];
  assign instr_req_o   = valid_req_q | valid_new_req;
  assign gnt           = instr_req_o & instr_gnt_i;

  always_comb begin
    instr_addr_o = {fetch_addr_q, 2'b00};
    if (branch_i) begin
      instr_addr_o = {addr_i[31:2], 2'b00};
    end else if (valid_req_q) begin
      instr_addr_o = {stored_addr_q, 2'b00};
    end
  end

  always_comb begin
    valid_req_d   = instr_req_o & ~instr_gnt_i;
    stored_addr_d = stored_addr_q;
    if (instr_req_o & ~instr_gnt_i & (branch_i | ~valid_req_q)) begin
      stored_addr_d = instr_addr_o[31:2];
    end

    fetch_addr_d = fetch_addr_q;
    if (branch_i) begin
      fetch_addr_d = addr_i[31:2] + {29'b0, gnt};
    end else if (gnt & ~valid_req_q) begin
      fetch_addr_d = fetch_addr_q + 30'd1;
    end else if (gnt) begin
      fetch_addr_d = stored_addr_q + 30'd1;
    end
  end

  // Thermometer tracking: a response retires slot 0, a grant fills the lowest
  // free slot after that shift, so a same-cycle rvalid+grant keeps the count.
  always_comb begin
    out_shift  = instr_rvalid_i ? (outstanding_q >> 1) : outstanding_q;
    disc_shift = instr_rvalid_i ? (discard_q >> 1) : discard_q;
    new_slot   = ~out_shift & (out_shift + NUM_REQS'(1));

    outstanding_d = out_shift | (gnt ? new_slot : '0);
    discard_d     = disc_shift;
    if (branch_i) begin
      discard_d = disc_shift | out_shift;
    end
    if (gnt) begin
      discard_d = discard_d & ~new_slot;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_q <= '0;
      discard_q     <= '0;
      valid_req_q   <= 1'b0;
      stored_addr_q <= '0;
      fetch_addr_q  <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      valid_req_q   <= valid_req_d;
      stored_addr_q <= stored_addr_d;
      fetch_addr_q  <= fetch_addr_d;
    end
  end

  assign fifo_clear_o = branch_i;
  assign fifo_addr_o  = addr_i;
  assign fifo_valid_o = instr_rvalid_i & ~discard_q[0];
  assign fifo_rdata_o = instr_rdata_i;
  assign fifo_err_o   = instr_err_i;
  assign busy_o       = (|outstanding_q) | instr_req_o;

endmodule

// File: tb/tb_ibex_fetch_req_ctrl.sv
// Directed bench for ibex_fetch_req_ctrl with a response scoreboard.
module tb_ibex_fetch_req_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i, branch_i;
  logic [31:0] addr_i;
  logic [1:0]  fifo_busy_i;
  logic        fifo_clear_o, fifo_valid_o, fifo_err_o;
  logic [31:0] fifo_addr_o, fifo_rdata_o;
  logic        instr_req_o, instr_gnt_i;
  logic [31:0] instr_addr_o;
  logic        instr_rvalid_i, instr_err_i;
  logic [31:0] instr_rdata_i;
  logic        busy_o;

  ibex_fetch_req_ctrl #(.NUM_REQS(2)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .branch_i(branch_i),
    .addr_i(addr_i), .fifo_busy_i(fifo_busy_i), .fifo_clear_o(fifo_clear_o),
    .fifo_valid_o(fifo_valid_o), .fifo_addr_o(fifo_addr_o),
    .fifo_rdata_o(fifo_rdata_o), .fifo_err_o(fifo_err_o),
    .instr_req_o(instr_req_o), .instr_gnt_i(instr_gnt_i),
    .instr_addr_o(instr_addr_o), .instr_rvalid_i(instr_rvalid_i),
    .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        disc;
  } sb_entry_t;

  sb_entry_t sb[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic note_grant(input logic [31:0] addr, input logic err);
    sb_entry_t e;
    e.data = addr ^ 32'hDEAD_0000;
    e.err  = err;
    e.disc = 1'b0;
    sb.push_back(e);
  endtask

  task automatic note_branch();
    foreach (sb[i]) sb[i].disc = 1'b1;
  endtask

  task automatic start_resp();
    instr_rvalid_i = 1'b1;
    if (sb.size() != 0) begin
      instr_rdata_i = sb[0].data;
      instr_err_i   = sb[0].err;
    end
  endtask

  task automatic check_resp(input string tag);
    sb_entry_t e;
    if (sb.size() == 0) begin
      chk({tag, "_underflow"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_valid"}, {31'd0, fifo_valid_o}, {31'd0, ~e.disc});
      if (!e.disc) begin
        chk({tag, "_rdata"}, fifo_rdata_o, e.data);
        chk({tag, "_err"}, {31'd0, fifo_err_o}, {31'd0, e.err});
      end
    end
  endtask

  initial begin
    rst_ni = 1'b0; req_i = 1'b0; branch_i = 1'b0; addr_i = '0; fifo_busy_i = '0;
    instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = '0; instr_err_i = 1'b0;
    #1;
    chk("rst_req", {31'd0, instr_req_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_fvalid", {31'd0, fifo_valid_o}, 32'd0);
    #7 rst_ni = 1'b1;
    tick();

    // Branch to 0x100 with a grant every cycle
    req_i = 1'b1; branch_i = 1'b1; addr_i = 32'h100; instr_gnt_i = 1'b1; #1;
    chk("b0_req", {31'd0, instr_req_o}, 32'd1);
    chk("b0_addr", instr_addr_o, 32'h100);
    chk("b0_clear", {31'd0, fifo_clear_o}, 32'd1);
    note_branch(); note_grant(32'h100, 1'b0);
    tick();
    branch_i = 1'b0; #1;
    chk("b1_addr", instr_addr_o, 32'h104);
    chk("b1_clear", {31'd0, fifo_clear_o}, 32'd0);
    note_grant(32'h104, 1'b0);
    tick();
    chk("full_req", {31'd0, instr_req_o}, 32'd0);
    chk("full_busy", {31'd0, busy_o}, 32'd1);
    tick();
    chk("full_req2", {31'd0, instr_req_o}, 32'd0);
    instr_gnt_i = 1'b0; start_resp(); #1;
    check_resp("r100");
    tick();
    start_resp(); #1;
    chk("pend_addr", instr_addr_o, 32'h108);
    check_resp("r104");
    tick();
    instr_rvalid_i = 1'b0;

    // Branch to 0x206 while the 0x108 request is pending, grant withheld
    branch_i = 1'b1; addr_i = 32'h206; #1;
    chk("h0_addr", instr_addr_o, 32'h204);
    note_branch();
    tick();
    branch_i = 1'b0; addr_i = 32'h0; #1;
    chk("h1_req", {31'd0, instr_req_o}, 32'd1);
    chk("h1_addr", instr_addr_o, 32'h204);
    tick();
    chk("h2_addr", instr_addr_o, 32'h204);
    instr_gnt_i = 1'b1; #1;
    chk("h3_addr", instr_addr_o, 32'h204);
    note_grant(32'h204, 1'b0);
    tick();
    instr_gnt_i = 1'b0; req_i = 1'b0; #1;
    chk("h4_addr", instr_addr_o, 32'h208);
    chk("h4_req", {31'd0, instr_req_o}, 32'd0);
    start_resp(); #1;
    check_resp("r204");
    tick();
    instr_rvalid_i = 1'b0;

    // Fill both slots, then branch to 0x400 while full
    req_i = 1'b1; instr_gnt_i = 1'b1; #1;
    chk("d0_addr", instr_addr_o, 32'h208);
    note_grant(32'h208, 1'b0);
    tick();
    chk("d1_addr", instr_addr_o, 32'h20C);
    note_grant(32'h20C, 1'b0);
    tick();
    branch_i = 1'b1; addr_i = 32'h400; #1;
    chk("d2_req", {31'd0, instr_req_o}, 32'd0);
    chk("d2_clear", {31'd0, fifo_clear_o}, 32'd1);
    note_branch();
    tick();
    branch_i = 1'b0; start_resp(); #1;
    chk("d3_clear", {31'd0, fifo_clear_o}, 32'd0);
    chk("d3_req", {31'd0, instr_req_o}, 32'd0);
    check_resp("r208");
    tick();
    start_resp(); #1;
    chk("d4_req", {31'd0, instr_req_o}, 32'd1);
    chk("d4_addr", instr_addr_o, 32'h400);
    check_resp("r20c");
    note_grant(32'h400, 1'b1);
    tick();
    chk("simul_outst", {30'd0, dut.outstanding_q}, 32'd1);
    req_i = 1'b0; instr_gnt_i = 1'b0; start_resp(); #1;
    check_resp("r400");
    tick();
    instr_rvalid_i = 1'b0; instr_err_i = 1'b0; #1;
    chk("idle_busy", {31'd0, busy_o}, 32'd0);

    // FIFO back-pressure
    fifo_busy_i = 2'b11; req_i = 1'b1; instr_gnt_i = 1'b1; #1;
    chk("fb11_req", {31'd0, instr_req_o}, 32'd0);
    tick();
    fifo_busy_i = 2'b01; #1;
    chk("fb01_req", {31'd0, instr_req_o}, 32'd1);
    chk("fb01_addr", instr_addr_o, 32'h404);
    note_grant(32'h404, 1'b0);
    tick();
    chk("fb01_blk", {31'd0, instr_req_o}, 32'd0);
    tick();
    chk("fb01_blk2", {31'd0, instr_req_o}, 32'd0);
    fifo_busy_i = 2'b00; #1;
    chk("fb00_req", {31'd0, instr_req_o}, 32'd1);
    chk("fb00_addr", instr_addr_o, 32'h408);
    note_grant(32'h408, 1'b0);
    tick();
    req_i = 1'b0; instr_gnt_i = 1'b0; start_resp(); #1;
    check_resp("r404");
    tick();
    start_resp(); #1;
    check_resp("r408");
    tick();
    instr_rvalid_i = 1'b0;

    // Pending request survives req_i falling; async reset clears it
    req_i = 1'b1; #1;
    tick();
    req_i = 1'b0; #1;
    chk("hold_req", {31'd0, instr_req_o}, 32'd1);
    chk("hold_addr", instr_addr_o, 32'h40C);
    #1 rst_ni = 1'b0; #1;
    chk("arst_req", {31'd0, instr_req_o}, 32'd0);
    chk("arst_busy", {31'd0, busy_o}, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
